// File: rtl/divarb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding and
// the prescale period helper.
package divarb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StRel  = 2'd2
  } state_e;

  // Terminal count for a prescale select: a tick every 2^sel cycles.
  function automatic int unsigned period_m1(input int unsigned sel);
    return (32'd1 << sel) - 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: rotating priority starting at ptr_i, or fixed
// lowest-index priority when DIVARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned R = 4,
  localparam int unsigned IdxW = $clog2(R)
) (
  input  logic [R-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [R-1:0]    win_o,
  output logic [IdxW-1:0] win_idx_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < R; i++) begin
`ifdef DIVARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (32'(ptr_i) + i) % R;
`endif
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        win_o[idx]     = 1'b1;
        win_idx_o      = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one clock divider among R requesters, delivering BURST tick enables per grant.
// Define DIVARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module divider_arbiter
  import divarb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned R     = 4,
  parameter int unsigned BURST = 4
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] sel,
  output logic [R-1:0]   gnt,
  output logic           busy,
  output logic [N-1:0]   prescale_out,
  output logic           tick,
  output logic [R-1:0]   done
);

  localparam int unsigned CntW  = 1 << N;
  localparam int unsigned IdxW  = $clog2(R);
  localparam int unsigned TickW = (BURST > 1) ? $clog2(BURST) : 1;

  state_e            state_q, state_d;
  logic [R-1:0]      gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [N-1:0]      prescale_q, prescale_d;
  logic [R-1:0]      done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [IdxW-1:0]   widx_q, widx_d;

  logic [R-1:0]      win;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   arb_ptr;
  logic [N-1:0]      sel_win;
  logic              cur_req, at_period, last_tick;

`ifdef DIVARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  assign arb_ptr = rr_ptr_q;
`endif

  rr_arbiter #(
    .R (R)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (arb_ptr),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  assign cur_req   = req[widx_q];
  assign at_period = (cnt_q == CntW'(period_m1(32'(prescale_q))));
  assign last_tick = (tick_cnt_q == TickW'(BURST - 1));

  always_comb begin
    sel_win = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (win[i]) sel_win = sel[i*N +: N];
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    prescale_d = prescale_q;
    done_d     = '0;
    cnt_d      = cnt_q;
    tick_cnt_d = tick_cnt_q;
    widx_d     = widx_q;
    tick       = 1'b0;
`ifndef DIVARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StRun;
          gnt_d      = win;
          busy_d     = 1'b1;
          prescale_d = sel_win;
          cnt_d      = '0;
          tick_cnt_d = '0;
          widx_d     = win_idx;
        end
      end
      StRun: begin
        // A dropped request aborts immediately and suppresses any coincident tick.
        if (!cur_req || (at_period && last_tick)) begin
          if (cur_req) begin
            tick           = 1'b1;
            done_d[widx_q] = 1'b1;
          end
          state_d    = StRel;
          gnt_d      = '0;
          busy_d     = 1'b0;
          prescale_d = '0;
          cnt_d      = '0;
          tick_cnt_d = '0;
        end else if (at_period) begin
          tick       = 1'b1;
          cnt_d      = '0;
          tick_cnt_d = tick_cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRel: begin
        state_d = StIdle;
`ifndef DIVARB_FIXED_PRIO_EN
        rr_ptr_d = (widx_q == IdxW'(R - 1)) ? '0 : widx_q + 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      prescale_q <= '0;
      done_q     <= '0;
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      prescale_q <= prescale_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      widx_q     <= widx_d;
    end
  end

`ifndef DIVARB_FIXED_PRIO_EN
  always_ff @(posedge clk_in) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign prescale_out = prescale_q;
  assign done         = done_q;

endmodule
